unstrip_lane_ctrl: RTL and testbench

Sequencing controller for the two-lane byte-unstripping path in the PHY receiver. It watches the per-lane valid flags, which change once every two `clk_2f` cycles. From them it generates the lane-select and read-enable that drive the unstripping mux, so bytes are merged in lane-0, lane-1 order on `clk_2f`. It also flags lane skew and phase slips, recovers automatically after an idle gap, and optionally keeps traffic and error statistics.

---
 rtl/unstrip_lane_ctrl.sv | 119 +++++++++++
 tb/tb_unstrip_lane_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/unstrip_lane_ctrl.sv
// Two-lane unstrip sequencer: lane select and read enable for the byte-merge mux, with skew/slip detection and gap recovery.
// Optional traffic/error counters behind `UNSTRIP_CTRL_STATS_EN`; without it pair_count/err_count read 0.
module unstrip_lane_ctrl #(
  parameter int GAP_CYCLES = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk_2f,
  input  logic             reset,
  input  logic             valid_par_0,
  input  logic             valid_par_1,
  output logic             sel_lane,
  output logic             read_en,
  output logic             active,
  output logic             lane_err,
  output logic [CNT_W-1:0] pair_count,
  output logic [7:0]       err_count
);

  typedef enum logic [1:0] {IDLE, ARM, RUN, ERROR} state_t;

  localparam logic [3:0] GAP_LIM = 4'(GAP_CYCLES);

  state_t     state;
  logic [3:0] gap_cnt;
  logic [3:0] gap_nxt;
  logic       both;
  logic       none;
  logic       mism;
  logic       err_go;

  assign both    = valid_par_0 & valid_par_1;
  assign none    = ~valid_par_0 & ~valid_par_1;
  assign mism    = valid_par_0 ^ valid_par_1;
  assign gap_nxt = gap_cnt + 4'd1;
  assign read_en = (state == RUN) & both;

  // On the second half of a word (sel_lane=1) any loss of "both valid" is a phase slip.
  always_comb begin
    err_go = 1'b0;
    case (state)
      IDLE:    err_go = mism;
      ARM:     err_go = mism;
      RUN:     err_go = sel_lane ? ~both : mism;
      default: err_go = 1'b0;
    endcase
  end

  always_ff @(posedge clk_2f) begin
    if (reset) begin
      state    <= IDLE;
      sel_lane <= 1'b0;
      active   <= 1'b0;
      lane_err <= 1'b0;
      gap_cnt  <= 4'd0;
    end else if (err_go) begin
      state    <= ERROR;
      sel_lane <= 1'b0;
      active   <= 1'b0;
      lane_err <= 1'b1;
      gap_cnt  <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (both) state <= ARM;
        end
        ARM: begin
          if (both) begin
            state    <= RUN;
            sel_lane <= 1'b0;
            active   <= 1'b1;
          end else if (none) begin
            state <= IDLE;
          end
        end
        RUN: begin
          if (both) begin
            sel_lane <= ~sel_lane;
          end else begin
            state    <= IDLE;
            sel_lane <= 1'b0;
            active   <= 1'b0;
          end
        end
        ERROR: begin
          if (!none) begin
            gap_cnt <= 4'd0;
          end else if (gap_nxt == GAP_LIM) begin
            state    <= IDLE;
            lane_err <= 1'b0;
            gap_cnt  <= 4'd0;
          end else begin
            gap_cnt <= gap_nxt;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef UNSTRIP_CTRL_STATS_EN
  logic pair_inc;

  assign pair_inc = (state == RUN) & sel_lane & both;

  always_ff @(posedge clk_2f) begin
    if (reset) begin
      pair_count <= '0;
      err_count  <= 8'd0;
    end else begin
      if (pair_inc) pair_count <= pair_count + CNT_W'(1);
      if (err_go && (err_count != 8'hFF)) err_count <= err_count + 8'd1;
    end
  end
`else
  assign pair_count = '0;
  assign err_count  = 8'd0;
`endif

endmodule

// File: tb/tb_unstrip_lane_ctrl.sv
// Scoreboard bench for unstrip_lane_ctrl: directed per-cycle vectors queue their expected outputs,
// a negedge monitor pops and compares. Counter expectations collapse to 0 when the stats build is off.
module tb_unstrip_lane_ctrl;

  localparam int GAP = 4;
  localparam int CW  = 4;
`ifdef UNSTRIP_CTRL_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  // {sel_lane, read_en, active, lane_err}
  localparam logic [3:0] O_IDLE = 4'b0000;
  localparam logic [3:0] O_R0   = 4'b0110;
  localparam logic [3:0] O_R1   = 4'b1110;
  localparam logic [3:0] O_R0N  = 4'b0010;
  localparam logic [3:0] O_R1N  = 4'b1010;
  localparam logic [3:0] O_ERR  = 4'b0001;

  logic          clk_2f      = 1'b0;
  logic          reset       = 1'b1;
  logic          valid_par_0 = 1'b0;
  logic          valid_par_1 = 1'b0;
  logic          sel_lane;
  logic          read_en;
  logic          active;
  logic          lane_err;
  logic [CW-1:0] pair_count;
  logic [7:0]    err_count;

  unstrip_lane_ctrl #(.GAP_CYCLES(GAP), .CNT_W(CW)) dut (
    .clk_2f      (clk_2f),
    .reset       (reset),
    .valid_par_0 (valid_par_0),
    .valid_par_1 (valid_par_1),
    .sel_lane    (sel_lane),
    .read_en     (read_en),
    .active      (active),
    .lane_err    (lane_err),
    .pair_count  (pair_count),
    .err_count   (err_count)
  );

  always #5 clk_2f = ~clk_2f;

  typedef struct {
    bit         chk;
    logic [3:0] o;
    int         pc;
    int         ec;
    int         id;
  } exp_t;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_bad  = 0;
  int   vec_id = 0;
  int   exp_pc = 0;
  int   exp_ec = 0;

  task automatic cyc(input logic r, input logic a, input logic b,
                     input logic [3:0] o, input bit chk = 1'b1);
    exp_t e;
    @(posedge clk_2f);
    #1;
    reset       = r;
    valid_par_0 = a;
    valid_par_1 = b;
    e.chk = chk;
    e.o   = o;
    e.pc  = exp_pc;
    e.ec  = exp_ec;
    e.id  = vec_id;
    vec_id++;
    sb.push_back(e);
  endtask

  exp_t       mon_e;
  logic [3:0] mon_got;
  int         pc_req;
  int         ec_req;

  always @(negedge clk_2f) begin
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      if (mon_e.chk) begin
        mon_got = {sel_lane, read_en, active, lane_err};
        pc_req  = STATS ? (mon_e.pc % (1 << CW)) : 0;
        ec_req  = STATS ? ((mon_e.ec > 255) ? 255 : mon_e.ec) : 0;
        n_vec++;
        if (mon_got !== mon_e.o || pair_count !== CW'(pc_req) || err_count !== 8'(ec_req)) begin
          n_bad++;
          $display("FAIL vec %0d: {sel,re,act,err}/pair/err got %b/%0d/%0d required %b/%0d/%0d",
                   mon_e.id, mon_got, pair_count, err_count, mon_e.o, pc_req, ec_req);
        end
      end
    end
  end

  initial begin
    // Reset state
    cyc(1'b1, 1'b0, 1'b0, O_IDLE, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, O_IDLE);
    cyc(1'b0, 1'b0, 1'b0, O_IDLE);

    // Clean burst of 10 cycles: sync word, then 4 pairs, clean drop at a word boundary
    for (int i = 0; i < 10; i++) begin
      exp_pc = (i < 2) ? 0 : (i - 2) / 2;
      cyc(1'b0, 1'b1, 1'b1, (i < 2) ? O_IDLE : ((i % 2) ? O_R1 : O_R0));
    end
    exp_pc = 4;
    cyc(1'b0, 1'b0, 1'b0, O_R0N);
    cyc(1'b0, 1'b0, 1'b0, O_IDLE);
    cyc(1'b0, 1'b0, 1'b0, O_IDLE);

    // Lane skew at a word boundary, then recovery after GAP idle cycles
    cyc(1'b0, 1'b1, 1'b1, O_IDLE);
    cyc(1'b0, 1'b1, 1'b1, O_IDLE);
    cyc(1'b0, 1'b1, 1'b1, O_R0);
    cyc(1'b0, 1'b1, 1'b1, O_R1);
    exp_pc = 5;
    cyc(1'b0, 1'b1, 1'b0, O_R0N);
    exp_ec = 1;
    repeat (4) cyc(1'b0, 1'b0, 1'b0, O_ERR);
    cyc(1'b0, 1'b0, 1'b0, O_IDLE);

    // Phase slip on a sel_lane=1 cycle; gap counter restarted by a valid cycle
    cyc(1'b0, 1'b1, 1'b1, O_IDLE);
    cyc(1'b0, 1'b1, 1'b1, O_IDLE);
    cyc(1'b0, 1'b1, 1'b1, O_R0);
    cyc(1'b0, 1'b1, 1'b1, O_R1);
    exp_pc = 6;
    cyc(1'b0, 1'b1, 1'b1, O_R0);
    cyc(1'b0, 1'b0, 1'b0, O_R1N);
    exp_ec = 2;
    repeat (3) cyc(1'b0, 1'b0, 1'b0, O_ERR);
    cyc(1'b0, 1'b1, 1'b0, O_ERR);
    repeat (4) cyc(1'b0, 1'b0, 1'b0, O_ERR);
    cyc(1'b0, 1'b0, 1'b0, O_IDLE);

    // Reset clears counters; then 17 pairs so the 4-bit pair counter wraps to 1
    cyc(1'b1, 1'b0, 1'b0, O_IDLE);
    exp_pc = 0;
    exp_ec = 0;
    cyc(1'b0, 1'b0, 1'b0, O_IDLE);
    for (int i = 0; i < 36; i++) begin
      exp_pc = (i < 2) ? 0 : (i - 2) / 2;
      cyc(1'b0, 1'b1, 1'b1, (i < 2) ? O_IDLE : ((i % 2) ? O_R1 : O_R0));
    end
    exp_pc = 17;
    cyc(1'b0, 1'b0, 1'b0, O_R0N);
    cyc(1'b0, 1'b0, 1'b0, O_IDLE);

    // 300 ERROR entries from IDLE, alternating the lone valid lane; err_count saturates
    for (int k = 1; k <= 300; k++) begin
      cyc(1'b0, k[0], ~k[0], O_IDLE);
      exp_ec = k;
      repeat (4) cyc(1'b0, 1'b0, 1'b0, O_ERR);
    end
    cyc(1'b0, 1'b0, 1'b0, O_IDLE);

    // Reset asserted mid-RUN: IDLE and zero counters on the next edge, then a clean resync
    cyc(1'b0, 1'b1, 1'b1, O_IDLE);
    cyc(1'b0, 1'b1, 1'b1, O_IDLE);
    cyc(1'b0, 1'b1, 1'b1, O_R0);
    cyc(1'b0, 1'b1, 1'b1, O_R1);
    exp_pc = 18;
    cyc(1'b1, 1'b1, 1'b1, O_R0);
    exp_pc = 0;
    exp_ec = 0;
    cyc(1'b0, 1'b1, 1'b1, O_IDLE);
    cyc(1'b0, 1'b1, 1'b1, O_IDLE);
    cyc(1'b0, 1'b0, 1'b0, O_R0N);
    cyc(1'b0, 1'b0, 1'b0, O_IDLE);

    @(posedge clk_2f);
    @(posedge clk_2f);
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left in scoreboard, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
